// File: rtl/difftest_csr_stream_tx.sv
// Transmit side of the difftest CSR-state channel.
// Buffers up to two {priv, csrs} snapshots and serializes each onto a
// valid/ready beat stream: changed CSRs in ascending index order, then a
// privilege beat (idx 16) that always closes the snapshot.
module difftest_csr_stream_tx #(
  parameter int DATA_W         = 76,
  parameter int NUM_CSR        = 16,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      update_valid,
  output logic                      update_ready,
  input  logic [1:0]                update_priv,
  input  logic [NUM_CSR*DATA_W-1:0] update_csrs,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4:0]                out_idx,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [7:0]                out_seq
);

  localparam int         CSRS_W   = NUM_CSR * DATA_W;
  localparam int         IDX_W    = $clog2(NUM_CSR);
  localparam logic [4:0] PRIV_IDX = 5'(NUM_CSR);

  typedef struct packed {
    logic [1:0]        priv;
    logic [CSRS_W-1:0] csrs;
  } snap_t;

  typedef enum logic {IDLE, SEND} state_t;

  snap_t              fifo_q [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  snap_t              head, in_snap, next_snap, shadow;
  logic               shadow_valid;
  state_t             state, state_next;
  logic [NUM_CSR-1:0] pending, pending_next, low_bit;
  logic [IDX_W-1:0]   low_idx;
  logic               push, pop, beat_fire, last_pend, have_next;

  // Bit i set when CSR i differs between a and b (all ones when not comparing).
  function automatic logic [NUM_CSR-1:0] change_mask(input logic [CSRS_W-1:0] a,
                                                     input logic [CSRS_W-1:0] b,
                                                     input logic cmp);
    logic [NUM_CSR-1:0] m;
    for (int i = 0; i < NUM_CSR; i++)
      m[i] = cmp ? (a[i*DATA_W +: DATA_W] != b[i*DATA_W +: DATA_W]) : 1'b1;
    return m;
  endfunction

  assign in_snap      = {update_priv, update_csrs};
  assign head         = fifo_q[rd_ptr];
  assign update_ready = (count != 2'd2);
  assign push         = update_valid && update_ready;
  assign beat_fire    = (state == SEND) && out_ready;
  assign last_pend    = (pending == '0);
  assign pop          = beat_fire && last_pend;
  // Snapshot that becomes head after a pop: the other slot, or one arriving now.
  assign have_next    = (count == 2'd2) || push;
  assign next_snap    = (count == 2'd2) ? fifo_q[~rd_ptr] : in_snap;
  assign low_bit      = pending & (~pending + 1'b1);

  // Lowest pending CSR index picks the current beat.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CSR - 1; i >= 0; i--)
      if (pending[i]) low_idx = IDX_W'(i);
  end

  // Next-state, pending mask and beat outputs.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    out_valid    = 1'b0;
    out_idx      = '0;
    out_data     = '0;
    out_last     = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pending_next = change_mask(head.csrs, shadow.csrs,
                                     (SKIP_UNCHANGED != 0) && shadow_valid);
          state_next   = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (!last_pend) begin
          out_idx  = 5'(low_idx);
          out_data = head.csrs[low_idx*DATA_W +: DATA_W];
        end else begin
          out_idx  = PRIV_IDX;
          out_data = {{(DATA_W-2){1'b0}}, head.priv};
          out_last = 1'b1;
        end
        if (beat_fire) begin
          if (!last_pend) begin
            pending_next = pending & ~low_bit;
          end else if (have_next) begin
            // Current head becomes the shadow on this edge, so compare against it.
            pending_next = change_mask(next_snap.csrs, head.csrs, SKIP_UNCHANGED != 0);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and pending mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  // FIFO pointers, occupancy, shadow validity and sequence number.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      shadow_valid <= 1'b0;
      out_seq      <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr       <= ~rd_ptr;
        shadow_valid <= 1'b1;
        out_seq      <= out_seq + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Snapshot storage; contents are don't-care while invalid, so no reset.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr] <= in_snap;
    if (pop)  shadow         <= head;
  end

endmodule

// File: tb/tb_difftest_csr_stream_tx.sv
// Directed bench for difftest_csr_stream_tx: snapshot table with expected
// change masks, beat scoreboard, plus stall, reset and sequence-wrap sequences.
module tb_difftest_csr_stream_tx;

  localparam int DW = 76;
  localparam int N  = 16;
  localparam int W  = N * DW;

  logic          clock = 1'b0;
  logic          reset;
  logic          update_valid, update_ready, out_valid, out_ready, out_last;
  logic [1:0]    update_priv;
  logic [W-1:0]  update_csrs;
  logic [4:0]    out_idx;
  logic [DW-1:0] out_data;
  logic [7:0]    out_seq;

  // Second instance with change suppression disabled, driven separately.
  logic          uv0, ur0, ov0, or0, ol0;
  logic [1:0]    up0;
  logic [W-1:0]  uc0;
  logic [4:0]    oi0;
  logic [DW-1:0] od0;
  logic [7:0]    os0;

  always #5 clock = ~clock;

  difftest_csr_stream_tx #(.DATA_W(DW), .NUM_CSR(N), .SKIP_UNCHANGED(1)) dut (
    .clock(clock), .reset(reset),
    .update_valid(update_valid), .update_ready(update_ready),
    .update_priv(update_priv), .update_csrs(update_csrs),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .out_seq(out_seq));

  difftest_csr_stream_tx #(.DATA_W(DW), .NUM_CSR(N), .SKIP_UNCHANGED(0)) dut0 (
    .clock(clock), .reset(reset),
    .update_valid(uv0), .update_ready(ur0),
    .update_priv(up0), .update_csrs(uc0),
    .out_valid(ov0), .out_ready(or0), .out_idx(oi0),
    .out_data(od0), .out_last(ol0), .out_seq(os0));

  typedef struct {
    logic [4:0]    idx;
    logic [DW-1:0] data;
    logic          last;
    logic [7:0]    seq;
  } beat_t;

  // Snapshot inputs plus hand-computed expected beat mask (bit 16 = priv beat).
  typedef struct {
    logic [1:0]   priv;
    logic [W-1:0] csrs;
    logic [16:0]  exp_mask;
    logic [7:0]   exp_seq;
  } snap_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    cnt0_q[$];
  int    cnt0 = 0;
  int    checks = 0;
  int    errors = 0;
  snap_t tab [6];

  logic [W-1:0] csr_a, csr_b, csr_f;

  // Scoreboard capture: a beat is accepted at the posedge after this negedge.
  always @(negedge clock)
    if (!reset && out_valid && out_ready)
      got_q.push_back('{idx: out_idx, data: out_data, last: out_last, seq: out_seq});

  // Beat count per snapshot on the non-suppressing instance.
  always @(negedge clock)
    if (!reset && ov0 && or0) begin
      cnt0 = cnt0 + 1;
      if (ol0) begin
        cnt0_q.push_back(cnt0);
        cnt0 = 0;
      end
    end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [W-1:0] mk_csrs(input logic [DW-1:0] base);
    logic [W-1:0] c;
    for (int i = 0; i < N; i++) c[i*DW +: DW] = base + DW'(i);
    return c;
  endfunction

  task automatic add_exp(input snap_t s);
    for (int i = 0; i < N; i++)
      if (s.exp_mask[i])
        exp_q.push_back('{idx: 5'(i), data: s.csrs[i*DW +: DW], last: 1'b0, seq: s.exp_seq});
    exp_q.push_back('{idx: 5'd16, data: DW'(s.priv), last: 1'b1, seq: s.exp_seq});
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_snap(input logic [1:0] p, input logic [W-1:0] c);
    int n;
    update_priv  = p;
    update_csrs  = c;
    update_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!update_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!update_ready) timeout("push_ready");
    @(posedge clock); #1;
    update_valid = 1'b0;
  endtask

  task automatic push0(input logic [1:0] p, input logic [W-1:0] c);
    int n;
    up0 = p;
    uc0 = c;
    uv0 = 1'b1;
    n = 0;
    @(negedge clock);
    while (!ur0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ur0) timeout("push0_ready");
    @(posedge clock); #1;
    uv0 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((got_q.size() != exp_q.size() || out_valid) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) timeout("drain");
    @(posedge clock); #1;
  endtask

  initial begin
    csr_a = mk_csrs(DW'(16'h100));
    csr_b = csr_a;
    csr_b[1*DW +: DW]  = DW'(16'hDEAD);
    csr_b[14*DW +: DW] = DW'(64'h8000_0000_0000_1234);
    csr_f = mk_csrs(DW'(16'h200));

    tab[0] = '{priv: 2'd3, csrs: csr_a, exp_mask: 17'h1FFFF, exp_seq: 8'd0};
    tab[1] = '{priv: 2'd3, csrs: csr_b, exp_mask: 17'h14002, exp_seq: 8'd1};
    tab[2] = '{priv: 2'd1, csrs: csr_b, exp_mask: 17'h10000, exp_seq: 8'd2};
    tab[3] = '{priv: 2'd3, csrs: csr_a, exp_mask: 17'h14002, exp_seq: 8'd3};
    tab[4] = '{priv: 2'd0, csrs: csr_b, exp_mask: 17'h14002, exp_seq: 8'd4};
    tab[5] = '{priv: 2'd2, csrs: csr_f, exp_mask: 17'h1FFFF, exp_seq: 8'd0};

    reset = 1'b1; update_valid = 1'b0; update_priv = '0; update_csrs = '0; out_ready = 1'b1;
    uv0 = 1'b0; up0 = '0; uc0 = '0; or0 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_update_ready", 128'(update_ready), 128'(1'b1));
    chk("rst_out_valid",    128'(out_valid),    128'(1'b0));
    chk("rst_out_idx",      128'(out_idx),      128'(0));
    chk("rst_out_data",     128'(out_data),     128'(0));
    chk("rst_out_last",     128'(out_last),     128'(1'b0));
    chk("rst_out_seq",      128'(out_seq),      128'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // First snapshot: out_valid appears two cycles after the push cycle.
    push_snap(tab[0].priv, tab[0].csrs);
    add_exp(tab[0]);
    @(negedge clock);
    chk("latency_t1_valid", 128'(out_valid), 128'(1'b0));
    @(negedge clock);
    chk("latency_t2_valid", 128'(out_valid), 128'(1'b1));
    @(posedge clock); #1;
    for (int k = 1; k < 3; k++) begin
      push_snap(tab[k].priv, tab[k].csrs);
      add_exp(tab[k]);
    end
    wait_drain();

    // Stall mid-snapshot while a second snapshot is buffered.
    push_snap(tab[3].priv, tab[3].csrs);
    add_exp(tab[3]);
    begin
      int n = 0;
      while (!(out_valid && out_idx == 5'd1) && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) timeout("stall_first_beat");
    end
    @(posedge clock); #1;
    out_ready    = 1'b0;
    update_priv  = tab[4].priv;
    update_csrs  = tab[4].csrs;
    update_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("stall_hold", {out_valid, out_idx, out_data, out_last, out_seq},
          {1'b1, 5'd14, DW'(16'h10E), 1'b0, 8'd3});
      if (c == 1) chk("stall_update_ready", 128'(update_ready), 128'(1'b0));
      @(posedge clock); #1;
      update_valid = 1'b0;
    end
    add_exp(tab[4]);
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("last_beat_ready_low", {out_last, update_ready}, {1'b1, 1'b0});
    @(negedge clock);
    chk("after_last_ready", 128'(update_ready), 128'(1'b1));
    chk("no_bubble", {out_valid, out_idx, out_seq}, {1'b1, 5'd1, 8'd4});
    @(posedge clock); #1;
    wait_drain();

    // Reset while beat idx5 of a full snapshot is on the bus.
    push_snap(tab[5].priv, tab[5].csrs);
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{idx: 5'(i), data: csr_f[i*DW +: DW], last: 1'b0, seq: 8'd5});
    begin
      int n = 0;
      while (!(out_valid && out_idx == 5'd4) && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) timeout("reset_beat4");
    end
    @(posedge clock); #1;
    chk("beat5_before_reset", {out_valid, out_idx}, {1'b1, 5'd5});
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_outputs", {update_ready, out_valid, out_idx, out_data, out_last, out_seq},
        {1'b1, 1'b0, 5'd0, DW'(0), 1'b0, 8'd0});
    reset = 1'b0;
    push_snap(tab[5].priv, tab[5].csrs);
    add_exp(tab[5]);
    wait_drain();

    // 256 more identical snapshots: single priv beats, sequence wraps to 0.
    for (int k = 1; k <= 256; k++) begin
      push_snap(tab[5].priv, tab[5].csrs);
      exp_q.push_back('{idx: 5'd16, data: DW'(tab[5].priv), last: 1'b1, seq: 8'(k)});
    end
    wait_drain();

    chk("beat_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].idx !== exp_q[i].idx || got_q[i].data !== exp_q[i].data ||
          got_q[i].last !== exp_q[i].last || got_q[i].seq !== exp_q[i].seq) begin
        errors++;
        $display("FAIL beat[%0d]: got idx=%0d data=%h last=%b seq=%0d, want idx=%0d data=%h last=%b seq=%0d",
                 i, got_q[i].idx, got_q[i].data, got_q[i].last, got_q[i].seq,
                 exp_q[i].idx, exp_q[i].data, exp_q[i].last, exp_q[i].seq);
      end
    end

    // Without suppression, identical snapshots still send all 17 beats.
    for (int k = 0; k < 3; k++) push0(2'd3, csr_a);
    begin
      int n = 0;
      while (cnt0_q.size() < 3 && n < 500) begin
        @(negedge clock);
        n++;
      end
      if (n >= 500) timeout("noskip_drain");
    end
    for (int k = 0; k < 3 && k < cnt0_q.size(); k++)
      chk("noskip_beats", 128'(cnt0_q[k]), 128'(17));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_csr_stream_tx.md
Name: difftest_csr_stream_tx

Overview:
- Transmit side of the difftest CSR-state channel.
- Accepts a full architectural CSR snapshot plus privilege level from the core's commit stage. Buffers up to two snapshots.
- Serializes each snapshot onto a narrow valid/ready beat stream consumed by the CSR-update sink and checker.
- Optionally suppresses CSRs unchanged since the previously transmitted snapshot, to cut simulation traffic.

Parameters:
- DATA_W, 76, width of each CSR value and of out_data.
- NUM_CSR, 16, number of CSRs per snapshot, fixed ordering below.
- SKIP_UNCHANGED, 1, 1 = send only changed CSRs; 0 = send all CSRs every snapshot.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- update_valid  in  1  snapshot offered this cycle.
- update_ready  out  1  snapshot buffer can accept.
- update_priv  in  2  privilege level of snapshot.
- update_csrs  in  NUM_CSR*DATA_W  packed CSRs; slice i = bits [i*DATA_W +: DATA_W].
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_idx  out  5  CSR index of beat; 16 = privilege beat.
- out_data  out  DATA_W  CSR value; privilege beat carries priv zero-extended.
- out_last  out  1  final beat of snapshot (always the privilege beat).
- out_seq  out  8  snapshot sequence number, constant across a snapshot's beats.

Behaviour:
- CSR index map:
  - 0 mstatus, 1 mepc, 2 mtval, 3 mscratch, 4 mcause, 5 mtvec, 6 mie, 7 mip
  - 8 medeleg, 9 mideleg, 10 sepc, 11 stval, 12 sscratch, 13 stvec, 14 satp, 15 scause
  - 16 priv (pseudo-index).
- Reset values:
  - update_ready=1; out_valid=0, out_idx=0, out_data=0, out_last=0, out_seq=0.
  - FIFO empty, shadow_valid=0, FSM=IDLE.
- Snapshot FIFO:
  - 2 entries, each {priv, csrs}.
  - update_ready = (count<2), with no combinational path from out_ready.
  - Push on update_valid&&update_ready.
  - Push and pop in the same cycle are both legal; count stays unchanged.
- Shadow register holds the last fully transmitted snapshot. shadow_valid is set at the first snapshot completion.
- FSM IDLE:
  - Waits for FIFO non-empty.
  - On that edge, load pending[15:0] = (SKIP_UNCHANGED && shadow_valid) ? (head.csr[i] != shadow.csr[i] per bit) : all ones.
  - Go to SEND.
- FSM SEND:
  - If pending != 0: out_idx = lowest set bit of pending, out_data = head.csr[out_idx], out_last=0.
  - If pending == 0: out_idx=16, out_data=priv zero-extended, out_last=1.
  - out_valid=1 throughout SEND.
  - On a non-last accept: clear that pending bit.
  - On a last accept:
    - pop FIFO, copy head into shadow, set shadow_valid, out_seq+=1 (wraps 255->0).
    - If FIFO still holds an entry after the pop, reload pending for it on the same edge and stay in SEND (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency:
  - A snapshot pushed into an empty FIFO in cycle t with FSM IDLE produces out_valid in cycle t+2.
  - Each beat takes 1 cycle under continuous out_ready.
- Stream rules:
  - While out_valid && !out_ready, out_idx/out_data/out_last/out_seq are held stable.
  - out_valid never drops before its beat is accepted.
- Beat order is strictly ascending idx with 16 last. Every snapshot emits ≥1 beat.
- Changed-mask is computed against shadow at load time. The shadow changes only at last-beat accept, so queued snapshots compare correctly in order.
- Reset asserted mid-snapshot:
  - Abandons it; all state returns to reset values, including shadow_valid=0.
  - The next snapshot is sent in full.

Test Plan:
- Reset, push snapshot with csr[i]=i+0x100, priv=3, out_ready=1 -> out_valid in cycle t+2; 17 beats idx 0..15 data 0x100..0x10F, then idx16 data 3 out_last=1; seq=0.
- Push second snapshot equal except mepc=0xDEAD, satp=0x8000_0000_0000_1234 -> beats idx1 0xDEAD, idx14 0x8000_0000_0000_1234, idx16 last; seq=1.
- Push identical snapshot -> single beat idx16 data=priv out_last=1, seq=2; with SKIP_UNCHANGED=0 -> full 17 beats instead.
- Hold out_ready=0 for 5 cycles mid-snapshot while pushing 2 more snapshots -> outputs stable; update_ready=0 after 2nd buffered push; rises the cycle after last-beat accept; next snapshot's first beat follows the last beat with no bubble.
- Assert reset during beat idx5 -> next cycle all outputs 0; next snapshot sends all 17 beats with seq=0.
- Send 257 identical snapshots -> out_seq runs 0..255, then 0 on the 257th.
